mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Owns the CPU's single byte-wide RAM/IO port and shares it between instruction fetch and the load/store buffer. Serialises 1/2/4-byte accesses into byte transactions, assembles little-endian read data, and stalls I/O writes on `io_buffer_full`. Sits inside `cpu` between the `ifetch`/`lsb` units and the `mem_a`/`mem_din`/`mem_dout`/`mem_wr` pins that `riscv_top` routes to RAM and UART.

## Interface
- `IO_MASK`, 2'b11: value of `addr[17:16]` that marks an I/O address.
- `clk_in`  in  1  clock; the one clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global ready; low freezes the block.
- `clear_in`  in  1  misprediction flush from ROB.
- `if_req`  in  1  fetch request, level, held until `if_done`.
- `if_addr`  in  32  fetch address (word read).
- `if_done`  out  1  one-cycle pulse, `if_data` valid.
- `if_data`  out  32  fetched word.
- `lsb_req`  in  1  LSB request, level, held until `lsb_done`.
- `lsb_wr`  in  1  1 = store, 0 = load.
- `lsb_size`  in  2  00 byte, 01 half, 10 word.
- `lsb_addr`  in  32  access address.
- `lsb_wdata`  in  32  store data (low bytes used).
- `lsb_done`  out  1  one-cycle pulse.
- `lsb_rdata`  out  32  load data, zero-extended (LSB sign-extends).
- `mem_din`  in  8  RAM read byte (address presented one cycle earlier).
- `mem_dout`  out  8  write byte.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  1 = write this cycle.
- `io_buffer_full`  in  1  UART TX buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE. All outputs registered.
- IDLE, `lsb_req`=1: accept LSB (priority over fetch, every time both pending). Else `if_req`=1: accept fetch, n=4. Latch owner, address, n (1/2/4), write data.
- Accept of read: `mem_a`<=addr, `mem_wr`<=0, idx<=0, -> READ.
- READ: each edge captures `mem_din` into byte (idx-1) once ≥1 address has been presented; presents addr+idx while idx<n. After byte n-1 captured -> DONE with owner's done=1, data valid.
- Accept of write: -> WRITE presenting byte 0 (`mem_a`=addr, `mem_dout`=wdata[7:0], `mem_wr`=1) unless stalled.
- WRITE stall: I/O address (`addr[17:16]`==IO_MASK) and `io_buffer_full`=1 at the edge -> next cycle `mem_wr`=0, idx not advanced. RAM addresses never stall.
- WRITE: after byte n-1 written -> DONE, `lsb_done`=1.
- DONE: done pulse high exactly this cycle; `mem_wr`=0; requests not sampled; -> IDLE.
- `clear_in`=1: fetch in READ/DONE aborted -> IDLE, `if_done` forced 0 next cycle. LSB access (committed) unaffected. Clear in IDLE: fetch request not accepted that edge.
- `rdy_in`=0: every register holds, `mem_wr` forced 0, `mem_a` held (RAM re-returns the same byte, so capture on resume is correct).
- Unowned data output holds last value.
- Address increment: 32-bit wrap (0xFFFFFFFF+1 = 0).

## Timing
- Reset: state IDLE, `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `if_done`=0, `lsb_done`=0, `if_data`=0, `lsb_rdata`=0.
- Read of n bytes, accepted at edge 0: byte i on `mem_a` cycle i+1, captured edge i+2; done high cycle n+2; next accept edge n+3. Fetch: done in cycle 6.
- Write of n bytes, no stall: byte i in cycle i+1; done high cycle n+1; next accept edge n+2. Each stall cycle adds 1.
- Requester must drop/change `req` before the edge after its done cycle.

## Structure
- Shared `defines.v`: state encodings, size encodings (`SIZE_B/H/W`), IO_MASK.
- Single module, no sub-module; byte-lane assembly is inline shift/insert.

## Test plan
- Fetch 0x00000100, RAM bytes 13 05 00 00 -> `mem_a` 0x100..0x103 cycles 1-4, `if_done` cycle 6, `if_data`=0x00000513.
- Both req same edge (fetch 0x200, LSB load word 0x1000) -> LSB served first, then fetch; neither done lost.
- LSB store half 0x1234 at 0x2000 -> writes 0x34@0x2000, 0x12@0x2001 cycles 1-2, `lsb_done` cycle 3.
- Store byte 0x41 to 0x30000 with `io_buffer_full` high 3 cycles -> `mem_wr`=0 for those cycles, then one write, done 3 cycles late.
- `clear_in` during fetch byte 2 -> IDLE next cycle, no `if_done`; new fetch accepted normally.
- `rdy_in` low 2 cycles mid-load -> correct data, done delayed exactly 2 cycles; reset mid-write -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : state/size encodings and byte-lane helpers for mem_arbiter
// Rev 1.0
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] IO_MASK_DEFAULT = 2'b11;

  // Unused size code 2'b11 is treated as a word access.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares the byte-wide RAM/IO port between fetch and the LSB
// Rev 1.0
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_MASK = IO_MASK_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic [2:0]  step_inc;
  logic [2:0]  step_dec;
  logic [31:0] next_addr;
  logic [31:0] buf_ins;

  function automatic logic io_stall(input logic [31:0] a, input logic full);
    return (a[17:16] == IO_MASK) && full;
  endfunction

  assign step_inc  = step_q + 3'd1;
  assign step_dec  = step_q - 3'd1;
  assign next_addr = addr_q + {29'd0, step_inc};
  // In READ, step_q counts edges since accept; the byte arriving now belongs to step_q-1.
  assign buf_ins   = insert_byte(buf_q, step_dec[1:0], mem_din);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    len_d       = len_q;
    step_d      = step_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (lsb_req) begin
          owner_d = OWN_LSB;
          addr_d  = lsb_addr;
          len_d   = size_to_len(lsb_size);
          wdata_d = lsb_wdata;
          step_d  = 3'd0;
          buf_d   = 32'd0;
          mem_a_d = lsb_addr;
          if (lsb_wr) begin
            state_d    = ST_WRITE;
            mem_dout_d = lsb_wdata[7:0];
            mem_wr_d   = !io_stall(lsb_addr, io_buffer_full);
          end else begin
            state_d = ST_READ;
          end
        end else if (if_req && !clear_in) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          len_d   = 3'd4;
          step_d  = 3'd0;
          buf_d   = 32'd0;
          mem_a_d = if_addr;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        step_d = step_inc;
        if (step_inc < len_q) begin
          mem_a_d = next_addr;
        end
        if (step_q != 3'd0) begin
          buf_d = buf_ins;
        end
        if (step_q == len_q) begin
          state_d = ST_DONE;
          if (owner_q == OWN_IF) begin
            if_done_d = 1'b1;
            if_data_d = buf_ins;
          end else begin
            lsb_done_d  = 1'b1;
            lsb_rdata_d = buf_ins;
          end
        end
        // A flush kills a speculative fetch; committed LSB reads run to completion.
        if (clear_in && (owner_q == OWN_IF)) begin
          state_d   = ST_IDLE;
          if_done_d = 1'b0;
          if_data_d = if_data_q;
        end
      end

      ST_WRITE: begin
        if (mem_wr_q) begin
          if (step_q == (len_q - 3'd1)) begin
            state_d    = ST_DONE;
            lsb_done_d = 1'b1;
          end else begin
            step_d     = step_inc;
            mem_a_d    = next_addr;
            mem_dout_d = wdata_q[{step_inc[1:0], 3'b000} +: 8];
            mem_wr_d   = !io_stall(next_addr, io_buffer_full);
          end
        end else begin
          mem_wr_d = !io_stall(mem_a_q, io_buffer_full);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= 32'd0;
      len_q       <= 3'd0;
      step_q      <= 3'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      lsb_rdata_q <= 32'd0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      step_q      <= step_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  // The write strobe is masked while frozen so the held byte is written once on resume.
  assign mem_wr    = mem_wr_q & rdy_in;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed and randomized transactions against a byte-RAM model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_size = 2'b00;
  logic [31:0] lsb_addr = 32'd0;
  logic [31:0] lsb_wdata = 32'd0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ram   [65536];
  bit          ram_v [65536];
  int          wr_count = 0;
  logic [31:0] tr_a  [64];
  logic        tr_wr [64];

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.IO_MASK(2'b11)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear_in      (clear_in),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_done       (if_done),
    .if_data       (if_data),
    .lsb_req       (lsb_req),
    .lsb_wr        (lsb_wr),
    .lsb_size      (lsb_size),
    .lsb_addr      (lsb_addr),
    .lsb_wdata     (lsb_wdata),
    .lsb_done      (lsb_done),
    .lsb_rdata     (lsb_rdata),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // 64 KiB byte store aliased on the low address bits; unwritten bytes follow a fixed pattern.
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_v[a[15:0]]) return ram[a[15:0]];
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // Synchronous RAM clocked only while the system is ready, so a frozen cycle re-presents the same byte.
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= ram_rd(mem_a);
    if (mem_wr) begin
      ram[mem_a[15:0]]   <= mem_dout;
      ram_v[mem_a[15:0]] <= 1'b1;
      wr_count           <= wr_count + 1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ram_rd(a + 32'(i));
    return r;
  endfunction

  function automatic int size_len(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_a"},     mem_a,                 32'd0);
    check({tag, "_mem_dout"},  32'(mem_dout),         32'd0);
    check({tag, "_mem_wr"},    32'(mem_wr),           32'd0);
    check({tag, "_if_done"},   32'(if_done),          32'd0);
    check({tag, "_lsb_done"},  32'(lsb_done),         32'd0);
    check({tag, "_if_data"},   if_data,               32'd0);
    check({tag, "_lsb_rdata"}, lsb_rdata,             32'd0);
  endtask

  // One request from IDLE to its done pulse. rdy_mode: 0 always ready, 1 random, 2 low where rdy_low[edge] is set.
  // act counts ready edges after the accept edge up to the done cycle.
  task automatic run_xfer(input bit fetch, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int full_k, input int rdy_mode, input logic [63:0] rdy_low,
                          output int done_cyc, output int act, output logic [31:0] data);
    int cyc;
    int fulls;
    bit r;
    done_cyc = -1;
    act      = 0;
    data     = 32'd0;
    fulls    = 0;
    for (int i = 0; i < 64; i++) begin
      tr_a[i]  = 32'd0;
      tr_wr[i] = 1'b0;
    end
    if (fetch) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      lsb_req   = 1'b1;
      lsb_wr    = wr;
      lsb_size  = size;
      lsb_addr  = addr;
      lsb_wdata = wdata;
    end
    rdy_in         = 1'b1;
    io_buffer_full = (full_k > 0);
    if (full_k > 0) fulls = 1;
    tick();
    cyc = 1;
    while (cyc < 60) begin
      case (rdy_mode)
        1:       rdy_in = ($urandom_range(0, 3) != 0);
        2:       rdy_in = !rdy_low[cyc];
        default: rdy_in = 1'b1;
      endcase
      io_buffer_full = (fulls < full_k);
      if (rdy_in && io_buffer_full) fulls++;
      #1;
      tr_a[cyc]  = mem_a;
      tr_wr[cyc] = mem_wr;
      if (fetch ? if_done : lsb_done) begin
        done_cyc = cyc;
        data     = fetch ? if_data : lsb_rdata;
        break;
      end
      r = rdy_in;
      tick();
      cyc++;
      if (r) act++;
    end
    if_req         = 1'b0;
    lsb_req        = 1'b0;
    rdy_in         = 1'b1;
    io_buffer_full = 1'b0;
    tick();
    check("done_pulse_width", 32'(fetch ? if_done : lsb_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          dc;
    int          act;
    int          n;
    int          k;
    int          wc0;
    int          lsb_cyc;
    int          if_cyc;
    bit          seen;
    bit          is_io;
    bit          fetch;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] e2;
    logic [31:0] mask;
    logic [31:0] last_if;
    logic [63:0] rmask;

    // Reset
    rst_in = 1'b1;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    rst_in = 1'b0;
    tick();

    // Store the instruction word, then fetch it
    wc0 = wr_count;
    run_xfer(0, 1, 2'b10, 32'h0000_0100, 32'h0000_0513, 0, 0, 64'd0, dc, act, d);
    check("st_word_done_cyc", 32'(dc), 32'd5);
    check("st_word_writes",   32'(wr_count - wc0), 32'd4);
    check("st_word_mem",      exp_read(32'h100, 4), 32'h0000_0513);

    run_xfer(1, 0, 2'b10, 32'h0000_0100, 32'd0, 0, 0, 64'd0, dc, act, d);
    check("fetch_done_cyc", 32'(dc), 32'd6);
    check("fetch_data",     d, 32'h0000_0513);
    for (int i = 0; i < 4; i++) check("fetch_mem_a", tr_a[i+1], 32'h100 + 32'(i));
    last_if = 32'h0000_0513;

    // Simultaneous requests: LSB first, fetch afterwards
    e  = exp_read(32'h1000, 4);
    e2 = exp_read(32'h200, 4);
    lsb_cyc = -1;
    if_cyc  = -1;
    if_req = 1'b1; if_addr = 32'h200;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h1000;
    tick();
    check("both_first_addr", mem_a, 32'h1000);
    for (int c = 1; c < 30; c++) begin
      if (lsb_done) begin
        lsb_cyc = c;
        check("both_lsb_data", lsb_rdata, e);
        lsb_req = 1'b0;
      end
      if (if_done) begin
        if_cyc = c;
        check("both_if_data", if_data, e2);
        if_req = 1'b0;
      end
      tick();
    end
    if_req  = 1'b0;
    lsb_req = 1'b0;
    check("both_lsb_cyc", 32'(lsb_cyc), 32'd6);
    check("both_if_cyc",  32'(if_cyc),  32'd13);
    last_if = e2;

    // Halfword store to RAM
    wc0 = wr_count;
    run_xfer(0, 1, 2'b01, 32'h2000, 32'hABCD_1234, 0, 0, 64'd0, dc, act, d);
    check("st_half_done_cyc", 32'(dc), 32'd3);
    check("st_half_wr_c1",    {tr_a[1][30:0], tr_wr[1]}, {31'h2000, 1'b1});
    check("st_half_wr_c2",    {tr_a[2][30:0], tr_wr[2]}, {31'h2001, 1'b1});
    check("st_half_mem",      exp_read(32'h2000, 2), 32'h0000_1234);
    check("st_half_writes",   32'(wr_count - wc0), 32'd2);

    // I/O store stalled by a full UART buffer for three edges
    wc0 = wr_count;
    run_xfer(0, 1, 2'b00, 32'h0003_0000, 32'h0000_0041, 3, 0, 64'd0, dc, act, d);
    check("io_done_cyc", 32'(dc), 32'd5);
    check("io_stall_wr", {29'd0, tr_wr[1], tr_wr[2], tr_wr[3]}, 32'd0);
    check("io_write_wr", 32'(tr_wr[4]), 32'd1);
    check("io_mem",      32'(ram_rd(32'h0003_0000)), 32'h41);
    check("io_writes",   32'(wr_count - wc0), 32'd1);

    // Flush while the third fetch byte is on the bus
    if_req = 1'b1; if_addr = 32'h400;
    tick(); tick(); tick();
    check("clr_byte2_addr", mem_a, 32'h402);
    clear_in = 1'b1; if_req = 1'b0;
    tick();
    clear_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (if_done) seen = 1'b1;
      tick();
    end
    check("clr_no_done",    32'(seen), 32'd0);
    check("clr_data_hold",  if_data, last_if);
    run_xfer(1, 0, 2'b10, 32'h0000_0100, 32'd0, 0, 0, 64'd0, dc, act, d);
    check("clr_refetch_cyc",  32'(dc), 32'd6);
    check("clr_refetch_data", d, 32'h0000_0513);

    // Flush in IDLE blocks that edge's fetch accept
    if_req = 1'b1; if_addr = 32'h100; clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    run_xfer(1, 0, 2'b10, 32'h0000_0100, 32'd0, 0, 0, 64'd0, dc, act, d);
    check("idle_clr_cyc", 32'(dc), 32'd6);

    // Two not-ready edges in the middle of a word load
    rmask = 64'd0;
    rmask[3] = 1'b1;
    rmask[4] = 1'b1;
    e = exp_read(32'h1000, 4);
    run_xfer(0, 0, 2'b10, 32'h1000, 32'd0, 0, 2, rmask, dc, act, d);
    check("rdy_done_cyc", 32'(dc), 32'd8);
    check("rdy_data",     d, e);

    // Fetch across the 32-bit address wrap
    e = exp_read(32'hFFFF_FFFE, 4);
    run_xfer(1, 0, 2'b10, 32'hFFFF_FFFE, 32'd0, 0, 0, 64'd0, dc, act, d);
    check("wrap_addr3", tr_a[3], 32'd0);
    check("wrap_data",  d, e);
    last_if = e;

    // Randomized mix of fetches, loads and stores
    for (int t = 0; t < 40; t++) begin
      k     = $urandom_range(0, 2);
      fetch = (k == 0);
      wr    = (k == 2);
      sz    = fetch ? 2'b10 : 2'($urandom_range(0, 2));
      n     = size_len(sz);
      a     = $urandom;
      is_io = ($urandom_range(0, 1) == 1) && wr;
      if (is_io) a[17:16] = 2'b11;
      else if (a[17:16] == 2'b11) a[17:16] = 2'b00;
      a     = a & ~(32'(n) - 32'd1);
      wd    = $urandom;
      k     = $urandom_range(0, 3);
      mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      e     = exp_read(a, n);
      wc0   = wr_count;
      run_xfer(fetch, wr, sz, a, wd, wr ? k : 0, $urandom_range(0, 1), 64'd0, dc, act, d);
      if (wr) begin
        check("rnd_wr_latency", 32'(act), 32'(is_io ? n + k : n));
        check("rnd_wr_mem",     exp_read(a, n), wd & mask);
        check("rnd_wr_count",   32'(wr_count - wc0), 32'(n));
      end else begin
        check("rnd_rd_latency", 32'(act), 32'(n + 1));
        check("rnd_rd_data",    d, e);
        check("rnd_rd_nowrite", 32'(wr_count - wc0), 32'd0);
      end
    end

    // Reset in the middle of a word store
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h5000; lsb_wdata = 32'hDEAD_BEEF;
    tick(); tick();
    rst_in = 1'b1; lsb_req = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_in = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
